// File: rtl/rs485_port_bank.sv
// Bank of half-duplex RS-485 transceiver controllers: a per-channel direction FSM
// sequences DE/nRE with turnaround guards; receive data passes a 2-FF synchroniser.
module rs485_port_bank #(
    parameter int N_CH  = 22,
    parameter int GUARD = 8,
    parameter int GW    = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            mode_wr,
    input  logic [4:0]      mode_ch,
    input  logic [1:0]      mode_val,
    input  logic [N_CH-1:0] tx_req,
    input  logic [N_CH-1:0] tx_d,
    output logic [N_CH-1:0] tx_ack,
    output logic [N_CH-1:0] tx_busy,
    output logic [N_CH-1:0] rx_q,
    input  logic [N_CH-1:0] pin_r,
    output logic [N_CH-1:0] pin_d,
    output logic [N_CH-1:0] pin_nre,
    output logic [N_CH-1:0] pin_de
);

    // state  | meaning
    // IDLE   | transceiver fully off (driver off, receiver off)
    // LISTEN | receiver on, waiting for a transmit request
    // SETUP  | driver on sending mark for the leading guard
    // TX     | driver on forwarding tx_d
    // HOLD   | driver on sending mark for the trailing guard
    // LOOPB  | driver and receiver both on for echo self-test
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LISTEN,
        ST_SETUP,
        ST_TX,
        ST_HOLD,
        ST_LOOPB
    } state_t;

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_RX   = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;
    localparam logic [1:0] MODE_LOOP = 2'd3;

    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t        state, state_nx;
        logic [GW-1:0] cnt, cnt_nx;
        logic [1:0]    mode;
        logic          sync1, sync2;
        logic          de_q, nre_q, d_q, ack_q, busy_q;
        logic          de_nx, nre_nx, d_nx, ack_nx, busy_nx;

        always_ff @(posedge clk) begin
            if (!n_rst) begin
                mode <= MODE_OFF;
            end else if (mode_wr && (mode_ch == 5'(g))) begin
                mode <= mode_val;
            end
        end

        always_ff @(posedge clk) begin
            if (!n_rst) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                de_q   <= 1'b0;
                nre_q  <= 1'b1;
                d_q    <= 1'b0;
                ack_q  <= 1'b0;
                busy_q <= 1'b0;
                sync1  <= 1'b1;
                sync2  <= 1'b1;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                de_q   <= de_nx;
                nre_q  <= nre_nx;
                d_q    <= d_nx;
                ack_q  <= ack_nx;
                busy_q <= busy_nx;
                sync1  <= pin_r[g];
                sync2  <= sync1;
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            case (state)
                ST_IDLE: begin
                    if (mode == MODE_RX || mode == MODE_HALF) begin
                        state_nx = ST_LISTEN;
                    end else if (mode == MODE_LOOP) begin
                        state_nx = ST_LOOPB;
                    end
                end
                ST_LISTEN: begin
                    // LOOP is entered via IDLE so the receiver path restarts cleanly
                    if (mode == MODE_OFF || mode == MODE_LOOP) begin
                        state_nx = ST_IDLE;
                    end else if (mode == MODE_HALF && tx_req[g]) begin
                        state_nx = ST_SETUP;
                        cnt_nx   = GUARD_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (!tx_req[g]) begin
                        state_nx = ST_HOLD;
                        cnt_nx   = GUARD_LOAD;
                    end else if (cnt == '0) begin
                        state_nx = ST_TX;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_TX: begin
                    if (!tx_req[g]) begin
                        state_nx = ST_HOLD;
                        cnt_nx   = GUARD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state_nx = (mode == MODE_OFF || mode == MODE_LOOP) ? ST_IDLE : ST_LISTEN;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_LOOPB: begin
                    if (mode != MODE_LOOP) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end

        // Pin values decode the current state and are registered, giving one clock of latency.
        always_comb begin
            de_nx   = 1'b0;
            nre_nx  = 1'b1;
            d_nx    = 1'b0;
            ack_nx  = 1'b0;
            busy_nx = 1'b0;
            case (state)
                ST_LISTEN: nre_nx = 1'b0;
                ST_SETUP: begin
                    de_nx   = 1'b1;
                    d_nx    = 1'b1;
                    busy_nx = 1'b1;
                end
                ST_TX: begin
                    de_nx   = 1'b1;
                    d_nx    = tx_d[g];
                    ack_nx  = 1'b1;
                    busy_nx = 1'b1;
                end
                ST_HOLD: begin
                    de_nx   = 1'b1;
                    d_nx    = 1'b1;
                    busy_nx = 1'b1;
                end
                ST_LOOPB: begin
                    de_nx  = 1'b1;
                    nre_nx = 1'b0;
                    d_nx   = tx_d[g];
                    ack_nx = 1'b1;
                end
                default: ;
            endcase
        end

        assign pin_de[g]  = de_q;
        assign pin_nre[g] = nre_q;
        assign pin_d[g]   = d_q;
        assign tx_ack[g]  = ack_q;
        assign tx_busy[g] = busy_q;
        assign rx_q[g]    = sync2 | nre_q;
    end

endmodule

// File: tb/tb_rs485_port_bank.sv
// Directed bench for rs485_port_bank: reset, RX table, HALF guard timing,
// mode-off during a frame, loopback echo, and reset mid-SETUP.
module tb_rs485_port_bank;
    localparam int N = 22;
    localparam logic [N-1:0] ALL1 = {N{1'b1}};

    logic         clk = 1'b0;
    logic         n_rst;
    logic         mode_wr;
    logic [4:0]   mode_ch;
    logic [1:0]   mode_val;
    logic [N-1:0] tx_req, tx_d, tx_ack, tx_busy, rx_q;
    logic [N-1:0] pin_r, pin_d, pin_nre, pin_de;
    logic [N-1:0] pin_r_drv;
    logic         loop7;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic r;
        logic req;
        logic exp_rx;
    } rx_vec_t;
    rx_vec_t rx_tbl [16];

    always #5 clk = ~clk;

    // Channel 7 can be looped back from its D pin to its R pin.
    always_comb begin
        pin_r = pin_r_drv;
        if (loop7) pin_r[7] = pin_d[7];
    end

    rs485_port_bank dut (
        .clk(clk), .n_rst(n_rst), .mode_wr(mode_wr), .mode_ch(mode_ch), .mode_val(mode_val),
        .tx_req(tx_req), .tx_d(tx_d), .tx_ack(tx_ack), .tx_busy(tx_busy), .rx_q(rx_q),
        .pin_r(pin_r), .pin_d(pin_d), .pin_nre(pin_nre), .pin_de(pin_de)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic mode_write(input int ch, input int val);
        mode_wr  = 1'b1;
        mode_ch  = 5'(ch);
        mode_val = 2'(val);
        tick();
        mode_wr  = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        logic [1:0] hist;
        logic       b;
        int         waited;

        rx_tbl[0]  = '{1'b1, 1'b0, 1'b1};
        rx_tbl[1]  = '{1'b1, 1'b1, 1'b1};
        rx_tbl[2]  = '{1'b1, 1'b0, 1'b1};
        rx_tbl[3]  = '{1'b1, 1'b1, 1'b1};
        rx_tbl[4]  = '{1'b0, 1'b1, 1'b1};
        rx_tbl[5]  = '{1'b0, 1'b1, 1'b0};
        rx_tbl[6]  = '{1'b0, 1'b0, 1'b0};
        rx_tbl[7]  = '{1'b0, 1'b1, 1'b0};
        rx_tbl[8]  = '{1'b1, 1'b1, 1'b0};
        rx_tbl[9]  = '{1'b1, 1'b0, 1'b1};
        rx_tbl[10] = '{1'b1, 1'b1, 1'b1};
        rx_tbl[11] = '{1'b1, 1'b1, 1'b1};
        rx_tbl[12] = '{1'b0, 1'b0, 1'b1};
        rx_tbl[13] = '{1'b0, 1'b1, 1'b0};
        rx_tbl[14] = '{1'b0, 1'b0, 1'b0};
        rx_tbl[15] = '{1'b0, 1'b1, 1'b0};

        n_rst = 1'b0; mode_wr = 1'b0; mode_ch = '0; mode_val = '0;
        tx_req = '0; tx_d = '0; pin_r_drv = ALL1; loop7 = 1'b0;

        // Reset
        tick(); tick();
        check("rst_de",   32'(pin_de),  32'(0));
        check("rst_nre",  32'(pin_nre), 32'(ALL1));
        check("rst_d",    32'(pin_d),   32'(0));
        check("rst_rxq",  32'(rx_q),    32'(ALL1));
        check("rst_busy", 32'(tx_busy), 32'(0));
        check("rst_ack",  32'(tx_ack),  32'(0));
        n_rst = 1'b1;
        tick();

        // RX on ch0: rx_q follows pin_r two edges later, tx_req ignored
        mode_write(0, 1);
        tick(); tick();
        check("rx_nre0", 32'(pin_nre[0]), 32'(0));
        for (int k = 0; k < 16; k++) begin
            pin_r_drv[0] = rx_tbl[k].r;
            tx_req[0]    = rx_tbl[k].req;
            tick();
            check($sformatf("rx_q0[%0d]", k), 32'(rx_q[0]), 32'(rx_tbl[k].exp_rx));
            check($sformatf("rx_de0[%0d]", k), 32'(pin_de[0]), 32'(0));
        end
        tx_req[0] = 1'b0; pin_r_drv[0] = 1'b1;

        // HALF on ch3: guard timing on both ends, re-request during HOLD
        mode_write(3, 2);
        tick(); tick();
        check("half_nre3", 32'(pin_nre[3]), 32'(0));
        tx_req[3] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("setup_de3[%0d]", i),  32'(pin_de[3]),  32'(i >= 2));
            check($sformatf("setup_ack3[%0d]", i), 32'(tx_ack[3]),  32'(i >= 10));
            check($sformatf("setup_nre3[%0d]", i), 32'(pin_nre[3]), 32'(i >= 2));
        end
        pat = 8'b1011_0010;
        for (int i = 0; i < 4; i++) begin
            tx_d[3] = pat[i];
            tick();
            check($sformatf("tx_d3[%0d]", i), 32'(pin_d[3]), 32'(pat[i]));
        end
        tx_req[3] = 1'b0; tx_d[3] = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            check($sformatf("hold_de3[%0d]", j), 32'(pin_de[3]), 32'(j <= 9 || j == 11));
            if (j <= 10) begin
                check($sformatf("hold_d3[%0d]", j),   32'(pin_d[3]),   32'(j >= 2 && j <= 9));
                check($sformatf("hold_nre3[%0d]", j), 32'(pin_nre[3]), 32'(j <= 9));
            end
            if (j == 5) tx_req[3] = 1'b1;
        end
        check("other_de", 32'(pin_de & ~(N'(1) << 3)), 32'(0));
        check("other_nre0", 32'(pin_nre[0]), 32'(0));
        tx_req[3] = 1'b0;
        waited = 0;
        while (pin_de[3] !== 1'b0 && waited < 40) begin
            tick();
            waited++;
        end
        check("release3_timeout", 32'(pin_de[3]), 32'(0));

        // ch5 switched OFF mid-frame: frame completes, then IDLE
        mode_write(5, 2);
        tick(); tick();
        tx_req[5] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("off_ack5", 32'(tx_ack[5]), 32'(1));
        mode_write(5, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("off_tx_de5[%0d]", i), 32'(pin_de[5]), 32'(1));
        end
        tx_req[5] = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check($sformatf("off_de5[%0d]", j), 32'(pin_de[5]), 32'(j <= 9));
        end
        check("off_nre5",  32'(pin_nre[5]), 32'(1));
        check("off_busy5", 32'(tx_busy[5]), 32'(0));
        check("off_rxq5",  32'(rx_q[5]),    32'(1));
        tx_req[5] = 1'b1;
        tick(); tick(); tick();
        check("off_req_ign5", 32'(pin_de[5]), 32'(0));
        tx_req[5] = 1'b0;

        // LOOP on ch7: rx_q echoes tx_d three edges later
        loop7 = 1'b1;
        mode_write(7, 3);
        tick(); tick();
        check("loop_de7",  32'(pin_de[7]),  32'(1));
        check("loop_nre7", 32'(pin_nre[7]), 32'(0));
        check("loop_ack7", 32'(tx_ack[7]),  32'(1));
        pat = 8'hA5;
        hist = 2'b00;
        for (int k = 0; k < 10; k++) begin
            b = (k < 8) ? pat[7 - k] : 1'b0;
            tx_d[7] = b;
            tick();
            check($sformatf("loop_rx7[%0d]", k), 32'(rx_q[7]), 32'(hist[1]));
            hist = {hist[0], b};
        end
        tx_d[7] = 1'b0;

        // All channels HALF, reset during SETUP; out-of-range writes ignored
        for (int c = 0; c < N; c++) mode_write(c, 2);
        tick(); tick(); tick();
        check("all_listen_nre", 32'(pin_nre), 32'(0));
        tx_req = ALL1;
        tick(); tick();
        check("all_setup_de", 32'(pin_de), 32'(ALL1));
        mode_write(25, 0);
        check("oob_de",   32'(pin_de),  32'(ALL1));
        check("oob_busy", 32'(tx_busy), 32'(ALL1));
        n_rst = 1'b0;
        tick();
        check("midrst_de",   32'(pin_de),  32'(0));
        check("midrst_busy", 32'(tx_busy), 32'(0));
        check("midrst_nre",  32'(pin_nre), 32'(ALL1));
        n_rst = 1'b1;
        tick(); tick(); tick();
        check("postrst_de", 32'(pin_de), 32'(0));
        mode_write(25, 2);
        tick(); tick(); tick();
        check("oob2_nre", 32'(pin_nre), 32'(ALL1));
        check("oob2_de",  32'(pin_de),  32'(0));
        tx_req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
